fetch_unit: RTL

- Instruction fetch stage directly downstream of the instruction memory core port (port A).
- Owns the PC and issues one-word reads to the instruction memory, which has 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing all in-flight and buffered words.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fetch_unit: PC owner, 1-cycle imem read issue, 2-entry output FIFO with   |
// | redirect flush. Optional perf counters under macro FETCH_PERF_CNT_EN.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic                  imem_en,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_hold  = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [31:0]           r_pc;
  logic [31:0]           r_pc_q;
  logic                  r_inflight;
  logic [1:0]            r_count;
  logic [31:0]           r_e0_pc;
  logic [DATA_WIDTH-1:0] r_e0_instr;
  logic [31:0]           r_e1_pc;
  logic [DATA_WIDTH-1:0] r_e1_instr;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;

  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_e0_pc;
  assign out_instr = r_e0_instr;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight & (r_state != c_st_flush);

  // Slots committed after this cycle; the pop frees one for a same-cycle issue.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rst_n & fetch_en & ~redirect_valid & (w_occ < 3'd2);

  assign imem_en   = w_issue;
  assign imem_we   = 1'b0;
  assign imem_addr = r_pc[ADDR_WIDTH+1:2];

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)
      w_state_nxt = c_st_flush;
    else if (fetch_en)
      w_state_nxt = c_st_run;
    else
      w_state_nxt = c_st_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_hold;
      r_pc       <= RESET_PC;
      r_pc_q     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc       <= redirect_pc & 32'hFFFF_FFFC;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc_q <= r_pc;
          r_pc   <= r_pc + 32'd4;
        end
      end
    end
  end

  // Shift FIFO: entry 0 is always the head driven to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_e0_pc    <= '0;
      r_e0_instr <= '0;
      r_e1_pc    <= '0;
      r_e1_instr <= '0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_e0_pc    <= r_pc_q;
            r_e0_instr <= imem_dout;
          end else begin
            r_e1_pc    <= r_pc_q;
            r_e1_instr <= imem_dout;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0_pc    <= r_e1_pc;
          r_e0_instr <= r_e1_instr;
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_e0_pc    <= r_e1_pc;
            r_e0_instr <= r_e1_instr;
            r_e1_pc    <= r_pc_q;
            r_e1_instr <= imem_dout;
          end else begin
            r_e0_pc    <= r_pc_q;
            r_e0_instr <= imem_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (out_valid & ~out_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule
`default_nettype wire
